hazard_stall_controller: RTL

Pipeline sequencing block for the 5-stage MIPS core. It detects load-use hazards, sequences the multi-cycle MULT/DIV unit (HI/LO producer), and orders branch flushes. It drives the load enables of the PC and IF/ID register and the bubble select that zeroes ID/EX control signals. It sits beside the ID stage and observes the ID/EX register outputs.

---
 rtl/hazard_stall_controller_if.sv | 37 +++
 rtl/hazard_stall_controller.sv | 117 +++++++++++
 2 files changed

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side handshake bundle for the hazard/stall controller.
// The master modport is the pipeline (ID decode and ID/EX register outputs).
// The slave modport is the controller, which returns load enables and MDU sequencing.
interface hazard_stall_controller_if;
  logic [4:0]  ID_RS;
  logic [4:0]  ID_RT;
  logic        ID_USES_RS;
  logic        ID_USES_RT;
  logic        ID_MDU_START;
  logic        ID_MDU_DIV;
  logic        ID_READS_HILO;
  logic        ID_BRANCH_TAKEN;
  logic        EX_LOAD_INSTR;
  logic        EX_RF_ENABLE;
  logic [4:0]  EX_REGEX;
  logic        PC_LE;
  logic        IF_ID_LE;
  logic        ID_EX_BUBBLE;
  logic        IF_ID_FLUSH;
  logic        MDU_START;
  logic        MDU_BUSY;
  logic [31:0] STALL_CYCLES;

  modport master (
    output ID_RS, ID_RT, ID_USES_RS, ID_USES_RT, ID_MDU_START, ID_MDU_DIV,
           ID_READS_HILO, ID_BRANCH_TAKEN, EX_LOAD_INSTR, EX_RF_ENABLE, EX_REGEX,
    input  PC_LE, IF_ID_LE, ID_EX_BUBBLE, IF_ID_FLUSH, MDU_START, MDU_BUSY,
           STALL_CYCLES
  );

  modport slave (
    input  ID_RS, ID_RT, ID_USES_RS, ID_USES_RT, ID_MDU_START, ID_MDU_DIV,
           ID_READS_HILO, ID_BRANCH_TAKEN, EX_LOAD_INSTR, EX_RF_ENABLE, EX_REGEX,
    output PC_LE, IF_ID_LE, ID_EX_BUBBLE, IF_ID_FLUSH, MDU_START, MDU_BUSY,
           STALL_CYCLES
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard/stall controller for the 5-stage MIPS core.
// It detects load-use hazards, sequences the multi-cycle MULT/DIV unit and
// orders branch flushes behind stalls. Decision outputs are Mealy (zero latency).
// Optional feature: define HAZ_STALL_COUNT_EN to build the saturating
// stall-cycle counter. Without it, STALL_CYCLES reads 0.
module hazard_stall_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16
) (
  input logic                     Clk,
  input logic                     Reset,
  hazard_stall_controller_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          load_use, mdu_hazard, stall;
  logic          pc_le, if_id_le, id_ex_bubble, if_id_flush, mdu_start;

  // Hazard detection: a load still in EX whose destination the ID instruction reads,
  // or an MDU consumer/producer arriving while the MDU is still busy.
  always_comb begin
    load_use   = bus.EX_LOAD_INSTR && bus.EX_RF_ENABLE && (bus.EX_REGEX != 5'd0) &&
                 ((bus.ID_USES_RS && (bus.ID_RS == bus.EX_REGEX)) ||
                  (bus.ID_USES_RT && (bus.ID_RT == bus.EX_REGEX)));
    mdu_hazard = (state == MDU_WAIT) && (bus.ID_READS_HILO || bus.ID_MDU_START);
    stall      = load_use || mdu_hazard;
  end

  // Pipeline control outputs; reset and stalls freeze the front end and bubble ID/EX,
  // and a taken branch is only flushed once nothing is stalling it.
  always_comb begin
    pc_le        = 1'b1;
    if_id_le     = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = bus.ID_BRANCH_TAKEN;
    mdu_start    = (state == RUN) && bus.ID_MDU_START;
    if (Reset || stall) begin
      pc_le        = 1'b0;
      if_id_le     = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b0;
      mdu_start    = 1'b0;
    end
  end

  // MDU sequencing: load the operation length on start, count down, and return
  // to RUN after the CNT==1 cycle so HI/LO readers are released only in RUN.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (mdu_start) begin
          state_next = MDU_WAIT;
          cnt_next   = bus.ID_MDU_DIV ? DIV_CNT : MULT_CNT;
        end
      end
      MDU_WAIT: begin
        if (cnt == CNT_ONE) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // State register; reset abandons any MDU operation in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign bus.PC_LE        = pc_le;
  assign bus.IF_ID_LE     = if_id_le;
  assign bus.ID_EX_BUBBLE = id_ex_bubble;
  assign bus.IF_ID_FLUSH  = if_id_flush;
  assign bus.MDU_START    = mdu_start;
  assign bus.MDU_BUSY     = (state == MDU_WAIT);

`ifdef HAZ_STALL_COUNT_EN
  logic [31:0] stall_cycles;

  // Saturating count of clock edges spent stalled.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign bus.STALL_CYCLES = stall_cycles;
`else
  assign bus.STALL_CYCLES = 32'h0;
`endif

endmodule
